// File: rtl/regfile_pkg.sv
// Shared register-file constants and operand types used by decode and writeback.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NRD   = 2;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);
  localparam int ZERO_ADDR = 0;

  typedef logic [DEF_WIDTH-1:0] reg_data_t;
  typedef logic [DEF_AW-1:0]    reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback view of the register file: read ports, write port, reservations.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NRD   = DEF_NRD,
  parameter int AW    = $clog2(DEPTH)
);

  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic                 flush;
  logic [AW:0]          pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, pend_cnt
  );

endinterface

// File: rtl/regfile_sb_busy.sv
// Pending-write scoreboard: one busy bit per register plus a running count of busy bits.
module regfile_sb_busy
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             flush,
  output logic [DEPTH-1:0] busy,
  output logic [AW:0]      pend_cnt
);

  logic             setHit;
  logic             clrHit;
  logic             incCnt;
  logic             decCnt;
  logic [DEPTH-1:0] busyNext;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    busyNext = busy;
    setHit   = rsv_en && !flush && !(ZERO_REG != 0 && rsv_addr == AW'(ZERO_ADDR));
    clrHit   = wr_en && !(ZERO_REG != 0 && wr_addr == AW'(ZERO_ADDR));
    // Same-address write+reserve leaves the bit set, so it can only ever count as a set.
    incCnt   = setHit && !busy[rsv_addr];
    decCnt   = clrHit && busy[wr_addr] && !(setHit && rsv_addr == wr_addr);
    if (clrHit) busyNext[wr_addr]  = 1'b0;
    if (setHit) busyNext[rsv_addr] = 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else if (flush) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busyNext;
      pend_cnt <= pend_cnt + (AW+1)'(incCnt) - (AW+1)'(decCnt);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file: multi-port combinational reads, write-through bypass,
// hardwired zero register and a pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busyVec;
  logic             wrHit;
  logic [AW-1:0]    addrK;

  assign wrHit = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == AW'(ZERO_ADDR));

  // NOTE: the storage array is reset because software relies on every register starting at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wrHit) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_sb_busy #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .flush    (bus.flush),
    .busy     (busyVec),
    .pend_cnt (bus.pend_cnt)
  );

  // Bypass is gated by reset so a write held through reset never leaks to the readers.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    addrK       = '0;
    for (int k = 0; k < NRD; k++) begin
      addrK = bus.rd_addr[k*AW +: AW];
      if (ZERO_REG != 0 && addrK == AW'(ZERO_ADDR)) begin
        bus.rd_data[k*WIDTH +: WIDTH] = '0;
        bus.rd_busy[k]                = 1'b0;
      end else if (BYPASS != 0 && rst && bus.wr_en && bus.wr_addr == addrK) begin
        bus.rd_data[k*WIDTH +: WIDTH] = bus.wr_data;
        bus.rd_busy[k]                = 1'b0;
      end else begin
        bus.rd_data[k*WIDTH +: WIDTH] = mem[addrK];
        bus.rd_busy[k]                = busyVec[addrK];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: table of single-cycle vectors plus reset and full-count sequences.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int W = 32;
  localparam int D = 32;
  localparam int N = 2;
  localparam int A = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(W), .DEPTH(D), .NRD(N), .AW(A)) bus ();

  regfile_sb #(
    .WIDTH(W), .DEPTH(D), .AW(A), .NRD(N), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        fl;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic re, input logic [4:0] ra, input logic fl,
                     input logic [4:0] a0, input logic [4:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] b, input logic [5:0] c);
    vec_t v;
    v.name = n; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.fl = fl;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.busy = b; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra, input logic fl,
                       input logic [4:0] a0, input logic [4:0] a1);
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rsv_en   = re;
    bus.rsv_addr = ra;
    bus.flush    = fl;
    bus.rd_addr  = {a1, a0};
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held: every address reads zero and idle.
    #12;
    for (int a = 0; a < D; a++) begin
      bus.rd_addr = {5'(a), 5'(a)};
      #1;
      check($sformatf("rst_data_r%0d", a), 64'(bus.rd_data), 64'h0);
      check($sformatf("rst_busy_r%0d", a), 64'({bus.rd_busy, bus.pend_cnt}), 64'h0);
    end
    @(negedge clk) rst = 1'b1;

    //   name          we wa  wd            re ra fl  a0 a1  d0            d1            busy   cnt
    add("wr7_bypass",  1, 7,  32'hDEADBEEF, 0, 0, 0,  7, 7,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
    add("rd7",         0, 0,  0,            0, 0, 0,  7, 7,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
    add("wr0",         1, 0,  32'h1234,     0, 0, 0,  0, 0,  0,            0,            2'b00, 0);
    add("rd0",         0, 0,  0,            0, 0, 0,  0, 7,  0,            32'hDEADBEEF, 2'b00, 0);
    add("bypass3",     1, 3,  32'hA5A5A5A5, 0, 0, 0,  7, 3,  32'hDEADBEEF, 32'hA5A5A5A5, 2'b00, 0);
    add("rsv4",        0, 0,  0,            1, 4, 0,  4, 3,  0,            32'hA5A5A5A5, 2'b00, 0);
    add("rsv4_again",  0, 0,  0,            1, 4, 0,  4, 3,  0,            32'hA5A5A5A5, 2'b01, 1);
    add("busy4",       0, 0,  0,            0, 0, 0,  4, 4,  0,            0,            2'b11, 1);
    add("wr4_bypass",  1, 4,  32'h44,       0, 0, 0,  4, 5,  32'h44,       0,            2'b00, 1);
    add("rd4_clear",   0, 0,  0,            0, 0, 0,  4, 4,  32'h44,       32'h44,       2'b00, 0);
    add("rsv9",        0, 0,  0,            1, 9, 0,  9, 4,  0,            32'h44,       2'b00, 0);
    add("wr_rsv9",     1, 9,  32'h99,       1, 9, 0,  9, 0,  32'h99,       0,            2'b00, 1);
    add("r9_busy",     0, 0,  0,            0, 0, 0,  9, 9,  32'h99,       32'h99,       2'b11, 1);
    add("rsv6",        0, 0,  0,            1, 6, 0,  6, 9,  0,            32'h99,       2'b10, 1);
    add("flush_rsv2",  1, 2,  32'h22,       1, 2, 1,  2, 6,  32'h22,       0,            2'b10, 2);
    add("after_flush", 0, 0,  0,            0, 0, 0,  2, 6,  32'h22,       0,            2'b00, 0);
    add("rsv0_wr7",    1, 7,  32'h77,       1, 0, 0,  0, 9,  0,            32'h99,       2'b00, 0);
    add("rd7_rd0",     0, 0,  0,            0, 0, 0,  7, 0,  32'h77,       0,            2'b00, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].fl,
            vecs[i].a0, vecs[i].a1);
      #2;
      check({vecs[i].name, "_d0"},   64'(bus.rd_data[31:0]),  64'(vecs[i].d0));
      check({vecs[i].name, "_d1"},   64'(bus.rd_data[63:32]), 64'(vecs[i].d1));
      check({vecs[i].name, "_busy"}, 64'(bus.rd_busy),        64'(vecs[i].busy));
      check({vecs[i].name, "_cnt"},  64'(bus.pend_cnt),       64'(vecs[i].cnt));
    end

    // Fill the scoreboard: r1..r31, then a reserve of r0 must not move the count.
    for (int r = 1; r < D; r++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, 5'(r), 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 31);
    #2;
    check("full_cnt",  64'(bus.pend_cnt), 64'd31);
    check("full_busy", 64'(bus.rd_busy),  64'b11);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    #2;
    check("rsv_r0_busy", 64'(bus.rd_busy), 64'b00);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rsv_r0_cnt", 64'(bus.pend_cnt), 64'd31);

    // Reset asserted in the middle of a write to r5.
    @(negedge clk);
    drive(1, 5, 32'h55555555, 0, 0, 0, 5, 7);
    #2;
    check("pre_rst_bypass", 64'(bus.rd_data), {32'h77, 32'h55555555});
    rst = 1'b0;
    #1;
    check("rst_mid_data", 64'(bus.rd_data), 64'h0);
    check("rst_mid_sb",   64'({bus.rd_busy, bus.pend_cnt}), 64'h0);
    @(posedge clk);
    #2;
    check("rst_edge_data", 64'(bus.rd_data), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 5, 7);
    #2;
    check("post_rst_r5_r7", 64'(bus.rd_data), 64'h0);
    check("post_rst_cnt",   64'(bus.pend_cnt), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with write-through bypass, hardwired zero register and a per-register pending-write scoreboard. It sits in the decode stage of the pipelined datapath. Decode reads operands and reserves destination registers at issue, and writeback commits results and releases the reservations. Hazard logic uses the per-port `rd_busy` flags to stall instead of re-deriving dependencies.

## Interface
Parameters:
- `WIDTH`, 32: data width in bits.
- `DEPTH`, 32: number of registers; must be a power of two, ≥ 2.
- `AW`, $clog2(DEPTH): address width; derived, do not override.
- `NRD`, 2: number of read ports, 1..4.
- `ZERO_REG`, 1: when 1, register 0 reads as 0, ignores writes and is never busy.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to matching reads.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rd_addr` in NRD*AW: read addresses; port k is bits [k*AW +: AW].
- `rd_data` out NRD*WIDTH: read data, same packing as `rd_addr`.
- `rd_busy` out NRD: port k's register has an outstanding reservation.
- `wr_en` in 1: write enable.
- `wr_addr` in AW: write address.
- `wr_data` in WIDTH: write data.
- `rsv_en` in 1: reserve destination register (instruction issue).
- `rsv_addr` in AW: register to reserve.
- `flush` in 1: synchronous clear of all reservations; data is kept.
- `pend_cnt` out AW+1: number of currently busy registers.

## Operation
- Storage: DEPTH × WIDTH flops. A busy bit vector `busy[DEPTH]` plus the `pend_cnt` counter form the scoreboard.
- Reset (`rst`=0, asynchronous): all registers become 0, all busy bits become 0, `pend_cnt` becomes 0.
  - Consequently `rd_data` = 0 and `rd_busy` = 0 on all ports while reset is held.
  - Reset mid-operation discards any in-flight write or reserve in that cycle.
- Read (combinational, per port k):
  - If `ZERO_REG` and `rd_addr[k]`=0, then `rd_data` = 0 and `rd_busy` = 0.
  - Else if `BYPASS` and `wr_en` and `wr_addr`==`rd_addr[k]`, then `rd_data` = `wr_data` and `rd_busy` = 0. The write being committed satisfies the reader.
  - Otherwise `rd_data` = `mem[rd_addr[k]]` and `rd_busy` = `busy[rd_addr[k]]`.
- Write: on a rising edge with `wr_en`, `mem[wr_addr]` ← `wr_data` and `busy[wr_addr]` is cleared. Writes to address 0 are dropped when `ZERO_REG`=1.
- Reserve: on a rising edge with `rsv_en`, `busy[rsv_addr]` is set. It has no effect on address 0 when `ZERO_REG`=1.
- Simultaneous write and reserve to the same address: the data is written and busy ends set, so a younger producer wins. Different addresses are handled independently.
- Reserving an already-busy register leaves it busy, with no count change. Writing a non-busy register leaves it non-busy, with no count change.
- `flush` clears all busy bits and sets `pend_cnt` to 0. A `wr_en` in the same cycle still commits data. An `rsv_en` in the same cycle is ignored, so flush has priority.
- `pend_cnt` arithmetic: next = cur + set − clr, where each of set and clr is 0 or 1 and counts only actual busy-bit transitions. The result never exceeds DEPTH − `ZERO_REG` and never underflows.

## Timing
- Read latency: 0 cycles (combinational from `rd_addr`, `wr_*` and state).
- Write visibility:
  - With `BYPASS`, data is visible in the same cycle.
  - Without `BYPASS`, it is visible from the cycle after the edge.
- Reserve visibility: `rd_busy` asserts in the cycle after the `rsv_en` edge.
- `pend_cnt` is registered and updates on the same edge as the busy bits.
- No handshake backpressure: the block accepts one write and one reserve every cycle.

## Structure
- A shared package `regfile_pkg` holds:
  - the default `WIDTH`/`DEPTH`/`NRD` constants;
  - `localparam ZERO_ADDR`;
  - the `reg_addr_t` / `reg_data_t` typedefs used by decode and writeback.
- One sub-module, `regfile_sb_busy`: the busy-bit vector plus `pend_cnt`, with the set/clear/flush priority logic. The top holds storage, read muxes and bypass.

## Test plan
- Reset: hold `rst`=0, read all addresses → `rd_data`=0, `rd_busy`=0, `pend_cnt`=0. Release reset, then assert `rst`=0 mid-write to r5 → r5 reads 0.
- Write/read: write 0xDEADBEEF to r7 → next cycle both ports read 0xDEADBEEF. Write 0x1234 to r0 → r0 reads 0.
- Bypass: same cycle `wr_en` r3=0xA5A5A5A5 and `rd_addr[1]`=3 → `rd_data[1]`=0xA5A5A5A5 combinationally, `rd_busy[1]`=0.
- Scoreboard:
  - Reserve r4 → next cycle `rd_busy`=1 and `pend_cnt`=1.
  - Write r4 → next cycle `rd_busy`=0 and `pend_cnt`=0.
  - Reserve r4 twice → `pend_cnt` stays at 1.
- Simultaneous events:
  - Same-cycle write r9 and reserve r9 → r9 holds new data and stays busy, with `pend_cnt` unchanged.
  - `flush` together with reserve r2 → all busy bits 0 and `pend_cnt`=0.
- Full count: reserve r1..r31 on consecutive cycles → `pend_cnt`=31. A reserve of r0 → `pend_cnt` stays at 31.
